axis_frame_checker: RTL and testbench
=====================================

AXIS_FRAME_CHECKER -- requirements
Module: axis_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, S_AXIS tdata width; multiple of 8 and >=32, else elaboration $fatal.
REQ-002 SHALL have parameter FRAME_LEN, default 256, expected beats per frame; range 2..65535.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port S_AXIS_tdata  input  DATA_WIDTH  stream data; pattern in bits [31:0].
REQ-006 SHALL have port S_AXIS_tdest  input  4  destination; captured, not checked.
REQ-007 SHALL have port S_AXIS_tkeep  input  DATA_WIDTH/8  byte enables.
REQ-008 SHALL have port S_AXIS_tlast  input  1  end of frame.
REQ-009 SHALL have port S_AXIS_tvalid  input  1  beat valid.
REQ-010 SHALL have port S_AXIS_tready  output  1  registered ready.
REQ-011 SHALL have port clr  input  1  synchronous clear of counters and flags.
REQ-012 SHALL have ports frame_cnt  output  32  (good frames); err_cnt  output  16  (bad frames, saturating); err_flags  output  5  (sticky); frame_done  output  1  (1-cycle pulse); last_tdest  output  4.

Function
REQ-013 SHALL accept a beat only on tvalid & tready; no state change on any other cycle.
REQ-014 SHALL check per beat: tdata[31:24]==8'hAA and tdata[15:8]==8'h00, else flag HDR (bit0).
REQ-015 SHALL check tdata[7:0]==beat index mod 256, index 0 at first beat of frame, else flag SEQ (bit1).
REQ-016 SHALL check tdata[23:16] constant within frame and equal to previous good-or-bad frame ID +1 mod 256; first frame after reset/clr seeds the ID, no check; mismatch flags ID (bit2).
REQ-017 SHALL flag LEN (bit3) when tlast arrives at beat count != FRAME_LEN, or beat count reaches FRAME_LEN without tlast (then enter FLUSH).
REQ-018 SHALL flag KEEP (bit4) when tkeep != all-ones.
REQ-019 SHALL implement FSM IDLE -> ACTIVE on first accepted beat; ACTIVE -> IDLE on tlast; ACTIVE -> FLUSH on missing-tlast LEN error; FLUSH discards beats (no checks) -> IDLE on tlast.
REQ-020 SHALL treat a single-beat frame (tvalid with tlast in IDLE) as a complete frame checked per REQ-017.
REQ-021 SHALL, one cycle after the tlast beat, pulse frame_done and increment frame_cnt (no error in frame) or err_cnt (any error), err_cnt saturating at 16'hFFFF, frame_cnt wrapping.
REQ-022 SHALL update err_flags one cycle after the offending beat; flags sticky until clr or rst.
REQ-023 SHALL give clr priority over a simultaneous frame completion: counters/flags zeroed, FSM to IDLE, ID re-seeded.
REQ-024 SHALL capture tdest of the tlast beat into last_tdest.

Reset
REQ-025 SHALL, on rst assertion, immediately force S_AXIS_tready=0, frame_cnt=0, err_cnt=0, err_flags=0, frame_done=0, last_tdest=0, FSM IDLE, ID unseeded.
REQ-026 SHALL drive S_AXIS_tready per REQ-027/028 from the first clk edge after rst release; rst mid-frame discards the partial frame without counting it.

Configuration
REQ-027 SHALL, with AXIS_CHK_BP_EN defined, drive tready from 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, advanced every cycle) as lfsr[0]|lfsr[1], ~75% duty.
REQ-028 SHALL, without AXIS_CHK_BP_EN, hold tready=1 continuously after reset release; LFSR not instantiated.

Structure
REQ-029 SHALL place in package axis_chk_pkg: FSM state enum (IDLE, ACTIVE, FLUSH), error bit index constants, header constants 8'hAA/8'h00, LFSR seed/taps.
REQ-030 SHALL instantiate sub-module axis_chk_lfsr (enable, 16-bit state out) only under AXIS_CHK_BP_EN.

Verification
REQ-031 SHALL cover: 3 clean frames of 256 beats, IDs 5,6,7 -> frame_cnt=3, err_cnt=0, err_flags=0, three frame_done pulses.
REQ-032 SHALL cover: beat 10 carries low byte 8'h0B -> err_flags=5'b00010, err_cnt=1, frame_cnt unchanged.
REQ-033 SHALL cover: tlast at beat 200 of 256, then clean frame -> LEN flag, err_cnt=1, next frame counted good, frame_cnt=1.
REQ-034 SHALL cover: frame without tlast (300 beats, tlast at 300) -> LEN flag at beat 256, FLUSH, beats 257-300 ignored, err_cnt=1.
REQ-035 SHALL cover: rst asserted at beat 100, then clean frame ID 9 -> tready low during rst, frame_cnt=1, no ID error.
REQ-036 SHALL cover: with AXIS_CHK_BP_EN, 2 clean frames under 50% random tvalid -> tready pattern matches LFSR model, frame_cnt=2.

Source files
------------

// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream frame checker.
// The optional AXIS_CHK_BP_EN build uses the LFSR seed/taps and lfsr_next().
package axis_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } chk_state_e;

  localparam int ERR_HDR  = 0;
  localparam int ERR_SEQ  = 1;
  localparam int ERR_ID   = 2;
  localparam int ERR_LEN  = 3;
  localparam int ERR_KEEP = 4;
  localparam int ERR_W    = 5;

  localparam logic [7:0] HDR_MAGIC = 8'hAA;
  localparam logic [7:0] HDR_ZERO  = 8'h00;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bits 15,13,12,10 select taps 16,14,13,11 (x^16+x^14+x^13+x^11+1).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_chk_lfsr.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random backpressure.
module axis_chk_lfsr
  import axis_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state_q <= LFSR_SEED;
    else if (en_i) state_q <= lfsr_next(state_q);
  end

  assign state_o = state_q;

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream test-pattern frame checker: header/sequence/ID/length/keep checks.
// Define AXIS_CHK_BP_EN to drive tready from an LFSR instead of holding it high.
module axis_frame_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [3:0]              S_AXIS_tdest,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
  input  logic                    S_AXIS_tlast,
  input  logic                    S_AXIS_tvalid,
  output logic                    S_AXIS_tready,
  input  logic                    clr,
  output logic [31:0]             frame_cnt,
  output logic [15:0]             err_cnt,
  output logic [4:0]              err_flags,
  output logic                    frame_done,
  output logic [3:0]              last_tdest
);

  if (DATA_WIDTH < 32 || (DATA_WIDTH % 8) != 0) begin : g_bad_dw
    $fatal(1, "DATA_WIDTH must be a multiple of 8 and >= 32");
  end
  if (FRAME_LEN < 2 || FRAME_LEN > 65535) begin : g_bad_len
    $fatal(1, "FRAME_LEN must be in 2..65535");
  end

  localparam logic [15:0]             LEN      = 16'(FRAME_LEN);
  localparam logic [DATA_WIDTH/8-1:0] KEEP_ALL = '1;

  logic rdy_d, rdy_q;

`ifdef AXIS_CHK_BP_EN
  logic [15:0] lfsr;
  axis_chk_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (1'b1),
    .state_o (lfsr)
  );
  assign rdy_d = lfsr[0] | lfsr[1];
`else
  assign rdy_d = 1'b1;
`endif

  chk_state_e        state_q, state_d;
  logic [15:0]       beat_q, beat_d;
  logic [7:0]        id_q, id_d;
  logic              seeded_q, seeded_d;
  logic              frm_err_q, frm_err_d;
  logic [31:0]       fcnt_q, fcnt_d;
  logic [15:0]       ecnt_q, ecnt_d;
  logic [ERR_W-1:0]  flags_q, flags_d;
  logic              done_q, done_d;
  logic [3:0]        tdest_q, tdest_d;

  logic              acc, fin, fin_bad;
  logic [15:0]       idx, cnt;
  logic [7:0]        rx_id;
  logic [ERR_W-1:0]  berr;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    id_d      = id_q;
    seeded_d  = seeded_q;
    frm_err_d = frm_err_q;
    fcnt_d    = fcnt_q;
    ecnt_d    = ecnt_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    tdest_d   = tdest_q;
    fin       = 1'b0;
    fin_bad   = 1'b0;

    acc   = S_AXIS_tvalid & rdy_q;
    rx_id = S_AXIS_tdata[23:16];
    idx   = (state_q == ST_IDLE) ? 16'd0 : beat_q;
    cnt   = idx + 16'd1;

    // The first beat is compared against the previous frame's ID, later beats against the first.
    berr           = '0;
    berr[ERR_HDR]  = (S_AXIS_tdata[31:24] != HDR_MAGIC) || (S_AXIS_tdata[15:8] != HDR_ZERO);
    berr[ERR_SEQ]  = S_AXIS_tdata[7:0] != idx[7:0];
    berr[ERR_ID]   = (state_q == ST_IDLE) ? (seeded_q && (rx_id != id_q + 8'd1))
                                          : (rx_id != id_q);
    berr[ERR_LEN]  = S_AXIS_tlast ? (cnt != LEN) : (cnt == LEN);
    berr[ERR_KEEP] = S_AXIS_tkeep != KEEP_ALL;

    if (acc) begin
      case (state_q)
        ST_IDLE, ST_ACTIVE: begin
          flags_d = flags_q | berr;
          beat_d  = cnt;
          if (state_q == ST_IDLE) begin
            id_d      = rx_id;
            seeded_d  = 1'b1;
            frm_err_d = |berr;
          end else begin
            frm_err_d = frm_err_q | (|berr);
          end
          if (S_AXIS_tlast) begin
            fin     = 1'b1;
            fin_bad = frm_err_d;
            state_d = ST_IDLE;
          end else if (cnt == LEN) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_FLUSH: begin
          if (S_AXIS_tlast) begin
            fin     = 1'b1;
            fin_bad = frm_err_q;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (fin) begin
      done_d  = 1'b1;
      tdest_d = S_AXIS_tdest;
      if (!fin_bad)                fcnt_d = fcnt_q + 32'd1;
      else if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
    end

    // Clear wins over a completing frame; the next frame re-seeds the ID.
    if (clr) begin
      state_d   = ST_IDLE;
      beat_d    = '0;
      seeded_d  = 1'b0;
      frm_err_d = 1'b0;
      fcnt_d    = '0;
      ecnt_d    = '0;
      flags_d   = '0;
      done_d    = 1'b0;
      tdest_d   = tdest_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q     <= 1'b0;
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      id_q      <= '0;
      seeded_q  <= 1'b0;
      frm_err_q <= 1'b0;
      fcnt_q    <= '0;
      ecnt_q    <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      tdest_q   <= '0;
    end else begin
      rdy_q     <= rdy_d;
      state_q   <= state_d;
      beat_q    <= beat_d;
      id_q      <= id_d;
      seeded_q  <= seeded_d;
      frm_err_q <= frm_err_d;
      fcnt_q    <= fcnt_d;
      ecnt_q    <= ecnt_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      tdest_q   <= tdest_d;
    end
  end

  assign S_AXIS_tready = rdy_q;
  assign frame_cnt     = fcnt_q;
  assign err_cnt       = ecnt_q;
  assign err_flags     = flags_q;
  assign frame_done    = done_q;
  assign last_tdest    = tdest_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Scoreboard bench for axis_frame_checker: random frames, frame-level reference model.
module tb_axis_frame_checker;

  localparam int FLEN = 256;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  dest;
  } beat_t;

  typedef struct {
    logic [31:0] fcnt;
    logic [15:0] ecnt;
    logic [4:0]  flags;
    logic [3:0]  dest;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] S_AXIS_tdata = '0;
  logic [3:0]  S_AXIS_tdest = '0;
  logic [3:0]  S_AXIS_tkeep = '0;
  logic        S_AXIS_tlast = 1'b0;
  logic        S_AXIS_tvalid = 1'b0;
  logic        S_AXIS_tready;
  logic        clr = 1'b0;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
  logic [4:0]  err_flags;
  logic        frame_done;
  logic [3:0]  last_tdest;

  axis_frame_checker #(.DATA_WIDTH(32), .FRAME_LEN(FLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tdest  (S_AXIS_tdest),
    .S_AXIS_tkeep  (S_AXIS_tkeep),
    .S_AXIS_tlast  (S_AXIS_tlast),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .clr           (clr),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt),
    .err_flags     (err_flags),
    .frame_done    (frame_done),
    .last_tdest    (last_tdest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int pushed = 0;

  beat_t fr[$];
  exp_t  exp_q[$];

  // Reference model state (frame level).
  logic [31:0] m_fcnt = '0;
  logic [15:0] m_ecnt = '0;
  logic [4:0]  m_flags = '0;
  logic [7:0]  m_prev = '0;
  logic        m_seeded = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_fcnt = '0; m_ecnt = '0; m_flags = '0; m_seeded = 1'b0;
  endfunction

  // Judge the whole frame from the rules, update cumulative totals, queue the expected result.
  function automatic void eval_push();
    int n, m;
    logic [4:0] f;
    logic [7:0] id0;
    logic [31:0] d;
    exp_t e;
    n = fr.size();
    m = (n < FLEN) ? n : FLEN;
    f = '0;
    id0 = fr[0].data[23:16];
    for (int i = 0; i < m; i++) begin
      d = fr[i].data;
      if (d[31:24] != 8'hAA || d[15:8] != 8'h00) f[0] = 1'b1;
      if (d[7:0] != 8'(i % 256)) f[1] = 1'b1;
      if (i == 0) begin
        if (m_seeded && id0 != 8'(m_prev + 8'd1)) f[2] = 1'b1;
      end else if (d[23:16] != id0) f[2] = 1'b1;
      if (fr[i].keep != 4'hF) f[4] = 1'b1;
    end
    if (n != FLEN) f[3] = 1'b1;
    m_prev = id0;
    m_seeded = 1'b1;
    m_flags = m_flags | f;
    if (f == 5'd0) m_fcnt = m_fcnt + 32'd1;
    else if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
    e.fcnt = m_fcnt; e.ecnt = m_ecnt; e.flags = m_flags; e.dest = fr[n-1].dest;
    exp_q.push_back(e);
    pushed++;
  endfunction

  task automatic build(input int n, input logic [7:0] id);
    beat_t b;
    fr.delete();
    for (int i = 0; i < n; i++) begin
      b.data = {8'hAA, id, 8'h00, 8'(i)};
      b.keep = 4'hF;
      b.last = (i == n - 1);
      b.dest = 4'($urandom);
      fr.push_back(b);
    end
  endtask

  // Called and returns at a negedge; sends the first ncut beats of fr.
  task automatic send(input int ncut, input int gap_pct);
    int w;
    for (int i = 0; i < ncut; i++) begin
      for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) @(negedge clk);
      S_AXIS_tdata  = fr[i].data;
      S_AXIS_tkeep  = fr[i].keep;
      S_AXIS_tlast  = fr[i].last;
      S_AXIS_tdest  = fr[i].dest;
      S_AXIS_tvalid = 1'b1;
      w = 0;
      while (!S_AXIS_tready && w < 64) begin @(negedge clk); w++; end
      if (w >= 64) chk("ready_timeout", 32'(S_AXIS_tready), 32'd1);
      @(posedge clk);
      if (fr[i].last) eval_push();
      @(negedge clk);
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tlast  = 1'b0;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    chk("clr_fcnt", frame_cnt, 32'd0);
    chk("clr_ecnt", 32'(err_cnt), 32'd0);
    chk("clr_flags", 32'(err_flags), 32'd0);
    chk("clr_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tready"}, 32'(S_AXIS_tready), 32'd0);
    chk({tag, "_fcnt"}, frame_cnt, 32'd0);
    chk({tag, "_ecnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_flags"}, 32'(err_flags), 32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_tdest"}, 32'(last_tdest), 32'd0);
  endtask

  // Monitor: every frame_done pops one expected frame result.
  always @(negedge clk) begin
    exp_t e;
    if (frame_done) begin
      done_seen++;
      if (exp_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_frame_cnt", frame_cnt, e.fcnt);
        chk("sb_err_cnt", 32'(err_cnt), 32'(e.ecnt));
        chk("sb_err_flags", 32'(err_flags), 32'(e.flags));
        chk("sb_last_tdest", 32'(last_tdest), 32'(e.dest));
      end
    end
  end

  // Ready model: low in reset; after release either always high or the LFSR pattern.
  logic        exp_rdy = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_rdy = 1'b0;
      m_lfsr  = 16'hACE1;
    end else begin
`ifdef AXIS_CHK_BP_EN
      exp_rdy = m_lfsr[0] | m_lfsr[1];
      m_lfsr  = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
      exp_rdy = 1'b1;
`endif
    end
  end
  always @(negedge clk) chk("tready", 32'(S_AXIS_tready), 32'(exp_rdy));

  initial begin
    #800us;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int k, mode, n;
    logic [7:0] nid;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #1 rst = 1'b0;
    @(negedge clk);

    // Three clean frames, IDs 5,6,7, 50% random tvalid.
    for (int f = 0; f < 3; f++) begin
      build(FLEN, 8'(5 + f));
      send(FLEN, 50);
    end
    @(negedge clk);
    chk("clean_fcnt", frame_cnt, 32'd3);
    chk("clean_ecnt", 32'(err_cnt), 32'd0);
    chk("clean_flags", 32'(err_flags), 32'd0);
    chk("clean_done_pulses", 32'(done_seen), 32'd3);

    // Sequence error at beat 10.
    do_clr();
    build(FLEN, 8'h10);
    b = fr[10]; b.data[7:0] = 8'h0B; fr[10] = b;
    send(FLEN, 25);
    @(negedge clk);
    chk("seq_flags", 32'(err_flags), 32'h02);
    chk("seq_ecnt", 32'(err_cnt), 32'd1);
    chk("seq_fcnt", frame_cnt, 32'd0);

    // Short frame (tlast at beat 200) then a clean frame.
    do_clr();
    build(200, 8'h20); send(200, 25);
    build(FLEN, 8'h21); send(FLEN, 25);
    @(negedge clk);
    chk("short_flags", 32'(err_flags), 32'h08);
    chk("short_ecnt", 32'(err_cnt), 32'd1);
    chk("short_fcnt", frame_cnt, 32'd1);

    // Missing tlast: 300 beats, beats past 256 are garbage and must be ignored.
    do_clr();
    build(300, 8'h30);
    for (int i = FLEN; i < 299; i++) begin
      b = fr[i]; b.data = $urandom; b.keep = 4'($urandom); fr[i] = b;
    end
    send(300, 25);
    build(FLEN, 8'h31); send(FLEN, 25);
    @(negedge clk);
    chk("long_flags", 32'(err_flags), 32'h08);
    chk("long_ecnt", 32'(err_cnt), 32'd1);
    chk("long_fcnt", frame_cnt, 32'd1);

    // Randomized mix of clean and faulty frames.
    do_clr();
    for (int f = 0; f < 10; f++) begin
      nid = m_seeded ? 8'(m_prev + 8'd1) : 8'($urandom);
      mode = $urandom_range(7);
      n = FLEN;
      if (mode == 5) n = 1;
      if (mode == 6) n = $urandom_range(FLEN - 1, 2);
      if (mode == 7) n = FLEN + $urandom_range(20, 1);
      if (mode == 4) nid = 8'(nid + 8'd2);
      build(n, nid);
      k = $urandom_range(FLEN - 1, 1);
      if (k >= n) k = n - 1;
      b = fr[k];
      case (mode)
        1: if ($urandom_range(1) == 0) b.data[31:24] = 8'h5A; else b.data[15:8] = 8'h01;
        2: b.keep = 4'($urandom_range(14));
        3: b.data[23:16] = b.data[23:16] ^ 8'h55;
        default: ;
      endcase
      fr[k] = b;
      send(n, 30);
    end
    @(negedge clk);
    chk("rand_fcnt", frame_cnt, m_fcnt);
    chk("rand_ecnt", 32'(err_cnt), 32'(m_ecnt));

    // Reset in the middle of a frame, then a clean frame with ID 9.
    build(FLEN, 8'h40);
    send(100, 25);
    #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_tready", 32'(S_AXIS_tready), 32'd0);
      chk("midrst_fcnt", frame_cnt, 32'd0);
      chk("midrst_ecnt", 32'(err_cnt), 32'd0);
      chk("midrst_flags", 32'(err_flags), 32'd0);
    end
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    build(FLEN, 8'h09); send(FLEN, 25);
    @(negedge clk);
    chk("rst_fcnt", frame_cnt, 32'd1);
    chk("rst_flags", 32'(err_flags), 32'd0);
    chk("rst_ecnt", 32'(err_cnt), 32'd0);

    repeat (3) @(negedge clk);
    chk("end_pending", 32'(exp_q.size()), 32'd0);
    chk("end_done_total", 32'(done_seen), 32'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
